// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - fixed-point types, box struct, FSM states and helpers for the SAT scanner
package collision_pkg;

  localparam int INT_BITS  = 10;
  localparam int FRAC_BITS = 22;
  localparam int W         = INT_BITS + FRAC_BITS;
  // Two guard bits so sums of in-range terms never wrap.
  localparam int WE        = W + 2;

  typedef logic signed [W-1:0]  fx_t;
  typedef logic signed [WE-1:0] fxe_t;

  typedef struct packed {
    fx_t pos_x;
    fx_t pos_y;
    fx_t u_x;
    fx_t u_y;
    fx_t v_x;
    fx_t v_y;
    fx_t half_w;
    fx_t half_h;
  } obb_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SEL,
    ST_PROJ,
    ST_CMP,
    ST_NEXT,
    ST_DONE
  } state_t;

  function automatic fxe_t fx_ext(input fx_t a);
    return WE'(a);
  endfunction

  // Full-width product, then drop the fractional bits with an arithmetic shift.
  function automatic fxe_t fx_mul(input fxe_t a, input fxe_t b);
    logic signed [2*WE-1:0] p;
    p = (2*WE)'(a) * (2*WE)'(b);
    p = p >>> FRAC_BITS;
    return p[WE-1:0];
  endfunction

  function automatic fxe_t fx_abs(input fxe_t a);
    return (a < 0) ? -a : a;
  endfunction

endpackage

// File: rtl/sat_axis_test.sv
// rtl/sat_axis_test.sv - one separating-axis test, dot products registered between PROJ and CMP
module sat_axis_test
  import collision_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  fx_t  n_x,
  input  fx_t  n_y,
  input  fxe_t d_x,
  input  fxe_t d_y,
  input  fx_t  ra,
  input  fx_t  o_u_x,
  input  fx_t  o_u_y,
  input  fx_t  o_v_x,
  input  fx_t  o_v_y,
  input  fx_t  o_half_w,
  input  fx_t  o_half_h,
  output logic separated
);

  fxe_t dot_d_q, dot_d_d;
  fxe_t dot_u_q, dot_u_d;
  fxe_t dot_v_q, dot_v_d;
  fxe_t rb;

  // Project the centre offset and the other box's axes onto n while load is high.
  always_comb begin
    dot_d_d = dot_d_q;
    dot_u_d = dot_u_q;
    dot_v_d = dot_v_q;
    if (load) begin
      dot_d_d = fx_mul(d_x, fx_ext(n_x)) + fx_mul(d_y, fx_ext(n_y));
      dot_u_d = fx_mul(fx_ext(o_u_x), fx_ext(n_x)) + fx_mul(fx_ext(o_u_y), fx_ext(n_y));
      dot_v_d = fx_mul(fx_ext(o_v_x), fx_ext(n_x)) + fx_mul(fx_ext(o_v_y), fx_ext(n_y));
    end
  end

  // Projection register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_d_q <= '0;
      dot_u_q <= '0;
      dot_v_q <= '0;
    end else begin
      dot_d_q <= dot_d_d;
      dot_u_q <= dot_u_d;
      dot_v_q <= dot_v_d;
    end
  end

  // Radius of the other box along n and the separation compare; touching separates.
  always_comb begin
    rb        = fx_mul(fx_ext(o_half_w), fx_abs(dot_u_q)) + fx_mul(fx_ext(o_half_h), fx_abs(dot_v_q));
    separated = fx_abs(dot_d_q) >= (fx_ext(ra) + rb);
  end

endmodule

// File: rtl/obb_sat_scanner.sv
// rtl/obb_sat_scanner.sv - sequential SAT scan of one query box against a target bank (COLLISION_EARLY_EXIT_EN)
module obb_sat_scanner
  import collision_pkg::*;
#(
  parameter int NUM_TARGETS = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            tgt_we,
  input  logic [((NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1)-1:0] tgt_addr,
  input  obb_t                                            tgt_obb,
  input  logic                                            tgt_clr,
  input  logic                                            start,
  input  obb_t                                            q_obb,
  output logic                                            busy,
  output logic                                            done,
  output logic [NUM_TARGETS-1:0]                          hit_mask,
  output logic                                            hit_any
);

  localparam int AW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

`ifdef COLLISION_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [AW-1:0]          t_q, t_d;
  logic [1:0]             k_q, k_d;
  logic [NUM_TARGETS-1:0] mask_q, mask_d;
  logic [NUM_TARGETS-1:0] hit_mask_q, hit_mask_d;
  logic [NUM_TARGETS-1:0] valid_q, valid_d;
  logic                   sep_any_q, sep_any_d;
  obb_t                   qry_q, qry_d;
  obb_t                   slots_q [NUM_TARGETS];
  obb_t                   slots_d [NUM_TARGETS];

  obb_t tgt_cur;
  obb_t oth;
  fx_t  n_x, n_y, ra;
  fxe_t d_x, d_y;
  logic axis_load;
  logic axis_sep;

  // Slot bank writes are only taken while idle; a clear wins over a write.
  always_comb begin
    slots_d = slots_q;
    valid_d = valid_q;
    if (state_q == ST_IDLE) begin
      if (tgt_clr) begin
        valid_d = '0;
      end else if (tgt_we && (int'(tgt_addr) < NUM_TARGETS)) begin
        slots_d[tgt_addr] = tgt_obb;
        valid_d[tgt_addr] = 1'b1;
      end
    end
  end

  // Axis select: k=0,1 use the query's axes against the target, k=2,3 the reverse.
  always_comb begin
    tgt_cur = slots_q[t_q];
    d_x     = fx_ext(tgt_cur.pos_x) - fx_ext(qry_q.pos_x);
    d_y     = fx_ext(tgt_cur.pos_y) - fx_ext(qry_q.pos_y);
    oth     = (k_q[1]) ? qry_q : tgt_cur;
    case (k_q)
      2'd0:    begin n_x = qry_q.u_x;   n_y = qry_q.u_y;   ra = qry_q.half_w;   end
      2'd1:    begin n_x = qry_q.v_x;   n_y = qry_q.v_y;   ra = qry_q.half_h;   end
      2'd2:    begin n_x = tgt_cur.u_x; n_y = tgt_cur.u_y; ra = tgt_cur.half_w; end
      default: begin n_x = tgt_cur.v_x; n_y = tgt_cur.v_y; ra = tgt_cur.half_h; end
    endcase
  end

  sat_axis_test u_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (axis_load),
    .n_x      (n_x),
    .n_y      (n_y),
    .d_x      (d_x),
    .d_y      (d_y),
    .ra       (ra),
    .o_u_x    (oth.u_x),
    .o_u_y    (oth.u_y),
    .o_v_x    (oth.v_x),
    .o_v_y    (oth.v_y),
    .o_half_w (oth.half_w),
    .o_half_h (oth.half_h),
    .separated(axis_sep)
  );

  // Scan FSM next-state, counters and working mask.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    k_d        = k_q;
    mask_d     = mask_q;
    hit_mask_d = hit_mask_q;
    sep_any_d  = sep_any_q;
    qry_d      = qry_q;
    axis_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          qry_d   = q_obb;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        mask_d  = '0;
        t_d     = '0;
        state_d = ST_SEL;
      end
      ST_SEL: begin
        if (!valid_q[t_q]) begin
          state_d = ST_NEXT;
        end else begin
          k_d       = 2'd0;
          sep_any_d = 1'b0;
          state_d   = ST_PROJ;
        end
      end
      ST_PROJ: begin
        axis_load = 1'b1;
        state_d   = ST_CMP;
      end
      ST_CMP: begin
        if (EARLY_EXIT && axis_sep) begin
          state_d = ST_NEXT;
        end else if (k_q == 2'd3) begin
          mask_d[t_q] = !(sep_any_q || axis_sep);
          state_d     = ST_NEXT;
        end else begin
          sep_any_d = sep_any_q | axis_sep;
          k_d       = k_q + 2'd1;
          state_d   = ST_PROJ;
        end
      end
      ST_NEXT: begin
        if (int'(t_q) == NUM_TARGETS - 1) begin
          // Publish on entry to DONE so hit_mask is already new while done is high.
          hit_mask_d = mask_q;
          state_d    = ST_DONE;
        end else begin
          t_d     = t_q + AW'(1);
          state_d = ST_SEL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, mask and slot bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      k_q        <= '0;
      mask_q     <= '0;
      hit_mask_q <= '0;
      valid_q    <= '0;
      sep_any_q  <= 1'b0;
      qry_q      <= '0;
      for (int i = 0; i < NUM_TARGETS; i++) slots_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      k_q        <= k_d;
      mask_q     <= mask_d;
      hit_mask_q <= hit_mask_d;
      valid_q    <= valid_d;
      sep_any_q  <= sep_any_d;
      qry_q      <= qry_d;
      for (int i = 0; i < NUM_TARGETS; i++) slots_q[i] <= slots_d[i];
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign hit_mask = hit_mask_q;
  assign hit_any  = |hit_mask_q;

endmodule

// File: tb/tb_obb_sat_scanner.sv
// tb/tb_obb_sat_scanner.sv - randomized self-checking bench for obb_sat_scanner against a behavioural SAT model
module tb_obb_sat_scanner;
  import collision_pkg::*;

  localparam int NT = 8;
  localparam longint ONE = 64'd4194304;
  localparam longint FAR = 64'd209715200;

`ifdef COLLISION_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tgt_we = 1'b0;
  logic          tgt_clr = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    tgt_addr = '0;
  obb_t          tgt_obb = '0;
  obb_t          q_obb = '0;
  logic          busy, done, hit_any;
  logic [NT-1:0] hit_mask;

  always #5 clk = ~clk;

  obb_sat_scanner #(.NUM_TARGETS(NT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tgt_we  (tgt_we),
    .tgt_addr(tgt_addr),
    .tgt_obb (tgt_obb),
    .tgt_clr (tgt_clr),
    .start   (start),
    .q_obb   (q_obb),
    .busy    (busy),
    .done    (done),
    .hit_mask(hit_mask),
    .hit_any (hit_any)
  );

  int            tests = 0;
  int            fails = 0;
  int            done_seen = 0;
  logic [NT-1:0] exp_mask = '0;
  logic [NT-1:0] held_mask = '0;
  obb_t          m_slot [NT];
  bit            m_valid [NT];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint msh(input longint a, input longint b);
    return (a * b) >>> FRAC_BITS;
  endfunction

  function automatic longint labs(input longint a);
    return (a < 0) ? -a : a;
  endfunction

  // Index of the first separating axis (query.u, query.v, target.u, target.v), 4 if none.
  function automatic int first_sep(input obb_t q, input obb_t t);
    longint dx, dy, nx, ny, ra, dd, du, dv, rb;
    obb_t   own, o;
    dx = longint'(t.pos_x) - longint'(q.pos_x);
    dy = longint'(t.pos_y) - longint'(q.pos_y);
    for (int k = 0; k < 4; k++) begin
      own = (k < 2) ? q : t;
      o   = (k < 2) ? t : q;
      nx  = (k % 2 == 0) ? longint'(own.u_x) : longint'(own.v_x);
      ny  = (k % 2 == 0) ? longint'(own.u_y) : longint'(own.v_y);
      ra  = (k % 2 == 0) ? longint'(own.half_w) : longint'(own.half_h);
      dd  = labs(msh(dx, nx) + msh(dy, ny));
      du  = labs(msh(longint'(o.u_x), nx) + msh(longint'(o.u_y), ny));
      dv  = labs(msh(longint'(o.v_x), nx) + msh(longint'(o.v_y), ny));
      rb  = msh(longint'(o.half_w), du) + msh(longint'(o.half_h), dv);
      if (dd >= ra + rb) return k;
    end
    return 4;
  endfunction

  task automatic model_scan(input obb_t q, output logic [NT-1:0] m, output int lat);
    int fs, e;
    m   = '0;
    lat = 2;
    for (int i = 0; i < NT; i++) begin
      if (!m_valid[i]) begin
        lat += 2;
      end else begin
        fs   = first_sep(q, m_slot[i]);
        m[i] = (fs == 4);
        e    = (EARLY && fs < 4) ? fs + 1 : 4;
        lat += 2 + 2 * e;
      end
    end
  endtask

  function automatic obb_t mk(input longint px, input longint py, input int ang,
                              input longint hw, input longint hh);
    obb_t   o;
    longint ux, uy, vx, vy;
    case (ang)
      1:       begin ux = 2965791; uy = 2965791; vx = -2965791; vy = 2965791; end
      2:       begin ux = 0;       uy = ONE;     vx = -ONE;     vy = 0;       end
      3:       begin ux = 3632376; uy = 2097152; vx = -2097152; vy = 3632376; end
      default: begin ux = ONE;     uy = 0;       vx = 0;        vy = ONE;     end
    endcase
    o.pos_x  = px[31:0];
    o.pos_y  = py[31:0];
    o.u_x    = ux[31:0];
    o.u_y    = uy[31:0];
    o.v_x    = vx[31:0];
    o.v_y    = vy[31:0];
    o.half_w = hw[31:0];
    o.half_h = hh[31:0];
    return o;
  endfunction

  function automatic obb_t rnd_box();
    longint px, py, hw, hh;
    px = longint'($urandom_range(0, 33554432)) - 16777216;
    py = longint'($urandom_range(0, 33554432)) - 16777216;
    hw = longint'($urandom_range(1048576, 8388608));
    hh = longint'($urandom_range(1048576, 8388608));
    return mk(px, py, int'($urandom_range(0, 3)), hw, hh);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input obb_t o);
    tgt_we   = 1'b1;
    tgt_addr = a[2:0];
    tgt_obb  = o;
    tick();
    tgt_we    = 1'b0;
    m_slot[a] = o;
    m_valid[a] = 1'b1;
  endtask

  task automatic clr();
    tgt_clr = 1'b1;
    tick();
    tgt_clr = 1'b0;
    for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
  endtask

  // One scan; optionally a same-cycle write, a write during busy and a start during busy.
  task automatic scan(input obb_t q, input bit same_we, input int sa, input obb_t so,
                      input int bwe_at, input int bwa, input obb_t bo,
                      input int bst_at, output int lat);
    logic [NT-1:0] em;
    int            el, d0, n;
    if (same_we) begin
      m_slot[sa]  = so;
      m_valid[sa] = 1'b1;
    end
    model_scan(q, em, el);
    exp_mask = em;
    d0       = done_seen;
    q_obb    = q;
    start    = 1'b1;
    if (same_we) begin
      tgt_we   = 1'b1;
      tgt_addr = sa[2:0];
      tgt_obb  = so;
    end
    tick();
    start  = 1'b0;
    tgt_we = 1'b0;
    n      = 1;
    while (done !== 1'b1 && n < 2000) begin
      if (n == bwe_at) begin
        tgt_we   = 1'b1;
        tgt_addr = bwa[2:0];
        tgt_obb  = bo;
      end
      if (n == bst_at) start = 1'b1;
      tick();
      tgt_we = 1'b0;
      start  = 1'b0;
      n++;
    end
    lat = n;
    chk("latency", n, el);
    chk("busy_at_done", busy, 1);
    repeat (4) tick();
    chk("done_pulses", done_seen - d0, 1);
    chk("busy_after_done", busy, 0);
  endtask

  // Output checker: mask/hit_any against the model on done, held stable otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done === 1'b1) begin
        done_seen++;
        chk("hit_mask", hit_mask, exp_mask);
        chk("hit_any", hit_any, |exp_mask);
        held_mask = exp_mask;
      end else begin
        chk("mask_stable", hit_mask, held_mask);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obb_t q0, t1, t2, t3, tf, nb;
    int   lat, d0, n;
    for (int i = 0; i < NT; i++) begin
      m_valid[i] = 1'b0;
      m_slot[i]  = '0;
    end
    q0 = mk(0, 0, 0, ONE, ONE);
    t1 = mk(6291456, 0, 0, ONE, ONE);
    t2 = mk(8388608, 0, 0, ONE, ONE);
    t3 = mk(7969178, 7969178, 1, ONE, ONE);
    tf = mk(FAR, FAR, 0, ONE, ONE);
    nb = '0;

    rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mask", hit_mask, 0);
    chk("reset_any", hit_any, 0);
    rst_n = 1'b1;
    tick();

    chk("model_overlap", first_sep(q0, t1), 4);
    chk("model_touch", first_sep(q0, t2), 0);
    chk("model_rotated", first_sep(q0, t3), 2);

    // Single overlapping target in slot 0.
    wr(0, t1);
    scan(q0, 0, 0, nb, -1, 0, nb, -1, lat);
    chk("t1_mask", hit_mask, 8'h01);
    chk("t1_any", hit_any, 1);
    chk("t1_latency", lat, 26);

    // Exact touch separates.
    wr(0, t2);
    scan(q0, 0, 0, nb, -1, 0, nb, -1, lat);
    chk("touch_mask", hit_mask, 8'h00);

    // Rotated target separated on its own axis.
    wr(0, t3);
    scan(q0, 0, 0, nb, -1, 0, nb, -1, lat);
    chk("rot_mask", hit_mask, 8'h00);

    // All slots, alternating overlap / far.
    for (int i = 0; i < NT; i++) wr(i, (i % 2 == 0) ? t1 : tf);
    scan(q0, 0, 0, nb, -1, 0, nb, -1, lat);
    chk("alt_mask", hit_mask, 8'h55);
    if (!EARLY) chk("alt_latency", lat, 82);

    // Reset in PROJ of slot 3 aborts the scan.
    q_obb = q0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(dut.state_q == ST_PROJ && dut.t_q == 3'd3) && n < 200) begin
      tick();
      n++;
    end
    chk("reach_slot3_proj", (n < 200), 1);
    d0    = done_seen;
    rst_n = 1'b0;
    for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
    held_mask = '0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_mask", hit_mask, 0);
    chk("abort_any", hit_any, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    repeat (100) tick();
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_idle", busy, 0);
    for (int i = 0; i < NT; i++) wr(i, (i % 2 == 0) ? t1 : tf);
    scan(q0, 0, 0, nb, -1, 0, nb, -1, lat);
    chk("rescan_mask", hit_mask, 8'h55);

    // Same-cycle start and write to slot 2 (far -> overlap).
    wr(2, tf);
    scan(q0, 1, 2, t1, -1, 0, nb, -1, lat);
    chk("same_cycle_mask", hit_mask, 8'h55);

    // Write and start during busy are ignored.
    scan(q0, 0, 0, nb, 6, 0, tf, 10, lat);
    chk("busy_we_mask", hit_mask, 8'h55);
    scan(q0, 0, 0, nb, -1, 0, nb, -1, lat);
    chk("slot0_unchanged", hit_mask, 8'h55);

    // Clear wins over a same-cycle write.
    tgt_clr  = 1'b1;
    tgt_we   = 1'b1;
    tgt_addr = 3'd0;
    tgt_obb  = t1;
    tick();
    tgt_clr = 1'b0;
    tgt_we  = 1'b0;
    for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
    scan(q0, 0, 0, nb, -1, 0, nb, -1, lat);
    chk("clr_mask", hit_mask, 8'h00);
    chk("clr_latency", lat, 18);

    // Randomized banks and queries.
    for (int r = 0; r < 14; r++) begin
      clr();
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(0, 3) != 0) wr(i, rnd_box());
      end
      scan(rnd_box(), 0, 0, nb, -1, 0, nb, -1, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
